// File: rtl/window_builder.sv
// Sliding WIN x WIN window generator over a raster pixel stream, one window per interior pixel.
// Latency: 1 cycle from the accepting edge to out_valid; one pixel per cycle at full throughput.
// Backpressure: single output stage; in_ready = !out_valid || out_ready, so a stalled window stalls input.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_pixel/in_sof/in_valid/in_ready raster pixel input; in_sof forces the pixel to position (0,0)
//   out_window                        flattened window, element row*WIN+col at [DATA_SIZE*r +: DATA_SIZE]
//   out_x/out_y/out_last              window centre and end-of-frame flag
//   out_valid/out_ready               output handshake
module window_builder #(
    parameter int WIN       = 15,
    parameter int WIN_SIZE  = WIN * WIN,
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 48
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_SIZE-1:0]            in_pixel,
    input  logic                            in_sof,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_SIZE*WIN_SIZE-1:0]   out_window,
    output logic [$clog2(IMG_W)-1:0]        out_x,
    output logic [$clog2(IMG_H)-1:0]        out_y,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_FIRST = XW'(WIN - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(WIN - 1);
    localparam logic [XW-1:0] X_MAX   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_HALF  = XW'((WIN - 1) / 2);
    localparam logic [YW-1:0] Y_HALF  = YW'((WIN - 1) / 2);

    // Raster position of the next pixel
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Output stage
    logic          out_valid_q, out_valid_d;
    logic          out_last_q,  out_last_d;
    logic [XW-1:0] out_x_q,     out_x_d;
    logic [YW-1:0] out_y_q,     out_y_d;

    // linebuf_q[0] holds the previous row, linebuf_q[WIN-2] the oldest row
    logic [DATA_SIZE-1:0] linebuf_q [WIN-1][IMG_W];
    // win_q[row][col]; row 0 top, col 0 leftmost. Doubles as the output register.
    logic [DATA_SIZE-1:0] win_q     [WIN][WIN];
    logic [DATA_SIZE-1:0] new_col   [WIN];

    logic          accept;
    logic          emit;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;

    always_comb begin
        accept = in_valid && in_ready;
        // Start of frame overrides the running position
        cx     = in_sof ? '0 : x_q;
        cy     = in_sof ? '0 : y_q;
        emit   = (cx >= X_FIRST) && (cy >= Y_FIRST);

        for (int r = 0; r < WIN - 1; r++) begin
            new_col[r] = linebuf_q[WIN-2-r][cx];
        end
        new_col[WIN-1] = in_pixel;

        x_d         = x_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;

        if (accept) begin
            if (cx == X_MAX) begin
                x_d = '0;
                y_d = (cy == Y_MAX) ? '0 : cy + YW'(1);
            end else begin
                x_d = cx + XW'(1);
                y_d = cy;
            end
            // Accept implies the output slot is free or draining this edge
            out_valid_d = emit;
            if (emit) begin
                out_x_d    = cx - X_HALF;
                out_y_d    = cy - Y_HALF;
                out_last_d = (cx == X_MAX) && (cy == Y_MAX);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    // Window only moves on accept, so it is stable while a window is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][WIN-1] <= new_col[r];
            end
        end
    end

    // Line buffer RAM: no reset, stale rows are never inside an emitted window
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = WIN - 2; k > 0; k--) begin
                linebuf_q[k][cx] <= linebuf_q[k-1][cx];
            end
            linebuf_q[0][cx] <= in_pixel;
        end
    end

    always_comb begin
        out_window = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                out_window[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] = win_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_window_builder.sv
module tb_window_builder;

    localparam int WIN   = 3;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int DS    = 8;
    localparam int WS    = WIN * WIN;
    localparam int WB    = DS * WS;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int H     = (WIN - 1) / 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_sof, in_valid, out_ready;
    logic [DS-1:0] in_pixel, in_pixel_b, off_b;
    logic          in_ready, out_last, out_valid;
    logic [WB-1:0] out_window;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          in_ready_b, out_last_b, out_valid_b;
    logic [WB-1:0] out_window_b;
    logic [XW-1:0] out_x_b;
    logic [YW-1:0] out_y_b;

    assign in_pixel_b = in_pixel + off_b;

    window_builder #(.WIN(WIN), .WIN_SIZE(WS), .DATA_SIZE(DS), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready), .out_window(out_window), .out_x(out_x), .out_y(out_y),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    window_builder #(.WIN(WIN), .WIN_SIZE(WS), .DATA_SIZE(DS), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel_b), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_window(out_window_b), .out_x(out_x_b), .out_y(out_y_b),
        .out_last(out_last_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    typedef struct {
        logic [WB-1:0] win;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference model: the frame as an image array plus the current raster position
    logic [DS-1:0] img [IMG_H][IMG_W];
    int mx, my;

    int  n_chk = 0, n_fail = 0;
    int  n_win, n_last, n_stall, n_exp;
    int  stall_req = 0, stall_left = 0;
    bit  rnd_mode = 0, gaps = 0;

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sad_of(input logic [WB-1:0] a, input logic [WB-1:0] b);
        int s = 0;
        for (int i = 0; i < WS; i++) begin
            int d;
            d = int'(a[DS*i +: DS]) - int'(b[DS*i +: DS]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    // Consumer readiness: steady, random, or a forced stall run
    initial out_ready = 1'b1;
    always begin
        @(posedge clk);
        #2;
        if (stall_req > 0) begin
            stall_left = stall_req;
            stall_req  = 0;
        end
        if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left--;
        end else begin
            out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compares every presented window with the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_ready)
            chk("in_ready_free", WB'(in_ready), WB'(1));
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_window: got window at (%0d,%0d), expected none", out_x, out_y);
            end else begin
                mon_e = q[0];
                chk("window", out_window, mon_e.win);
                chk("out_x", WB'(out_x), WB'(mon_e.x));
                chk("out_y", WB'(out_y), WB'(mon_e.y));
                chk("out_last", WB'(out_last), WB'(mon_e.last));
                chk("b_pos", WB'({out_x_b, out_y_b, out_last_b}), WB'({mon_e.x, mon_e.y, mon_e.last}));
                chk("sad", WB'(sad_of(out_window, out_window_b)), WB'(WS * int'(off_b)));
                if (out_ready) begin
                    void'(q.pop_front());
                    n_win++;
                    if (out_last) n_last++;
                end else begin
                    chk("in_ready_hold", WB'({in_ready, in_ready_b}), WB'(0));
                    n_stall++;
                end
            end
        end
    end

    task automatic send(input logic [DS-1:0] pix, input bit sof);
        int   tries = 0;
        bit   rdy   = 0;
        bit   e;
        exp_t et;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_pixel = pix;
        in_sof   = sof;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            tries++;
        end while (!rdy && tries < 200);
        if (!rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready in 200 cycles, expected acceptance");
            #1 in_valid = 1'b0;
            return;
        end
        if (sof) begin mx = 0; my = 0; end
        img[my][mx] = pix;
        e = (mx >= WIN - 1) && (my >= WIN - 1);
        if (e) begin
            et.win = '0;
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    et.win[DS*(r*WIN+c) +: DS] = img[my-(WIN-1)+r][mx-(WIN-1)+c];
            et.x    = XW'(mx - H);
            et.y    = YW'(my - H);
            et.last = (mx == IMG_W - 1) && (my == IMG_H - 1);
            q.push_back(et);
            n_exp++;
        end
        mx++;
        if (mx == IMG_W) begin
            mx = 0;
            my = (my == IMG_H - 1) ? 0 : my + 1;
        end
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("valid_latency", WB'(out_valid), WB'(e));
        chk("valid_latency_b", WB'(out_valid_b), WB'(e));
    endtask

    task automatic frame(input int base, input bit rnd_pix, input int sx, input int sy,
                         input int npix, input bit sof0);
        for (int i = 0; i < npix; i++) begin
            int x, y;
            x = i % IMG_W;
            y = i / IMG_W;
            send(rnd_pix ? DS'($urandom_range(0, 255)) : DS'(base + 16 * y + x), (i == 0) && sof0);
            if (x == sx && y == sy) stall_req = 4;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d windows outstanding, expected 0", q.size());
        end
    endtask

    task automatic scen_begin();
        n_win = 0; n_last = 0; n_stall = 0; n_exp = 0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; off_b = '0;
        mx = 0; my = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("rst_out_valid", WB'(out_valid), WB'(0));
        chk("rst_out_last", WB'(out_last), WB'(0));
        chk("rst_out_x", WB'(out_x), WB'(0));
        chk("rst_out_y", WB'(out_y), WB'(0));
        chk("rst_window", out_window, '0);
        chk("rst_in_ready", WB'(in_ready), WB'(1));
        @(posedge clk); #1;

        // First window and full frame count
        scen_begin();
        frame(0, 0, -1, -1, NPIX, 1);
        drain();
        chk("s2_count", WB'(n_win), WB'(NWIN));
        chk("s2_last", WB'(n_last), WB'(1));
        chk("s2_stall", WB'(n_stall), WB'(0));

        // Backpressure on the window centred at (2,1)
        scen_begin();
        frame(0, 0, 3, 2, NPIX, 1);
        drain();
        chk("s3_count", WB'(n_win), WB'(NWIN));
        chk("s3_last", WB'(n_last), WB'(1));
        chk("s3_stall", WB'(n_stall), WB'(4));

        // Start of frame at pixel (1,2) abandons the frame
        scen_begin();
        frame(0, 0, -1, -1, 2 * IMG_W + 1, 1);
        frame(128, 0, -1, -1, NPIX, 1);
        drain();
        chk("s4_count", WB'(n_win), WB'(NWIN));
        chk("s4_last", WB'(n_last), WB'(1));

        // Reset while a window is pending
        frame(0, 0, -1, -1, 2 * IMG_W + WIN, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_valid", WB'({out_valid, out_valid_b}), WB'(0));
        chk("s5_pos", WB'({out_x, out_y, out_last}), WB'(0));
        chk("s5_window", out_window, '0);
        q.delete();
        mx = 0; my = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        scen_begin();
        frame(0, 0, -1, -1, NPIX, 0);
        drain();
        chk("s5_count", WB'(n_win), WB'(NWIN));
        chk("s5_last", WB'(n_last), WB'(1));

        // Right-camera frame offset by one
        off_b = 8'd1;
        scen_begin();
        frame(0, 0, -1, -1, NPIX, 1);
        drain();
        chk("s6_count", WB'(n_win), WB'(NWIN));
        off_b = 8'd0;

        // Random pixels, random consumer, input gaps, one aborted frame
        rnd_mode = 1; gaps = 1;
        scen_begin();
        repeat (3) frame(0, 1, -1, -1, NPIX, 1);
        frame(0, 1, -1, -1, $urandom_range(1, NPIX - 1), 1);
        frame(0, 1, -1, -1, NPIX, 1);
        drain();
        chk("rnd_count", WB'(n_win), WB'(n_exp));
        chk("rnd_last", WB'(n_last), WB'(4));
        rnd_mode = 0; gaps = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
